// File: rtl/pipeline_rr_arbiter_pkg.sv
// Shared types and helpers for the pipeline round-robin arbiter.
// Optional feature macro: PIPE_ARB_LOCK_EN (see rtl/pipeline_rr_arbiter.sv).
package pipe_arb_pkg;

   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? unsigned'($clog2(n)) : 1;
   endfunction

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_ID_WIDTH = id_width(DEF_NUM_REQ);

   typedef logic [DEF_ID_WIDTH-1:0] arb_id_t;

   localparam logic OUT_VALID_RST = 1'b0;

endpackage

// File: rtl/pipeline_rr_arbiter_if.sv
// Requester, output and stage-control signals of the arbiter.
// req_last_i only exists when PIPE_ARB_LOCK_EN is defined.
interface pipeline_rr_arbiter_if #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
) ();
   import pipe_arb_pkg::*;

   localparam int unsigned ID_WIDTH = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
`ifdef PIPE_ARB_LOCK_EN
   logic [NUM_REQ-1:0]            req_last_i;
`endif
   logic                          m_data_valid;
   logic                          m_data_ready;
   logic [DATA_WIDTH-1:0]         m_data_data;
   logic [ID_WIDTH-1:0]           m_data_id;
   logic                          s_ctrl_stall;
   logic                          s_ctrl_flush;
   logic                          s_status_busy;

   // Arbiter side.
   modport slave (
      input  req_valid_i, req_data_i,
`ifdef PIPE_ARB_LOCK_EN
      input  req_last_i,
`endif
      input  m_data_ready, s_ctrl_stall, s_ctrl_flush,
      output req_ready_o, m_data_valid, m_data_data, m_data_id, s_status_busy
   );

   // Environment side: requesters, consumer and pipeline control.
   modport master (
      output req_valid_i, req_data_i,
`ifdef PIPE_ARB_LOCK_EN
      output req_last_i,
`endif
      output m_data_ready, s_ctrl_stall, s_ctrl_flush,
      input  req_ready_o, m_data_valid, m_data_data, m_data_id, s_status_busy
   );

endinterface

// File: rtl/pipeline_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first eligible request at or above
// the pointer, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  i_req,
   input  logic [ID_WIDTH-1:0] i_ptr,
   input  logic [NUM_REQ-1:0]  i_mask,
   output logic                o_grant_valid,
   output logic [ID_WIDTH-1:0] o_grant_idx
);

   logic [NUM_REQ-1:0] w_elig;

   assign w_elig = i_req & i_mask;

   function automatic int unsigned wrap_idx(input int unsigned p, input int unsigned off);
      return (p + off >= NUM_REQ) ? p + off - NUM_REQ : p + off;
   endfunction

   // Walk offsets high to low so the smallest offset from the pointer wins.
   always_comb begin
      o_grant_valid = 1'b0;
      o_grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_elig[wrap_idx(int'(i_ptr), unsigned'(i))]) begin
            o_grant_valid = 1'b1;
            o_grant_idx   = ID_WIDTH'(wrap_idx(int'(i_ptr), unsigned'(i)));
         end
      end
   end

endmodule

// File: rtl/pipeline_rr_arbiter.sv
// Round-robin arbiter feeding one output register with stall/flush stage control.
// Define PIPE_ARB_LOCK_EN to keep a requester's multi-beat packet contiguous.
module pipeline_rr_arbiter
   import pipe_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic                   clk_i,
   input logic                   rst_ni,
   pipeline_rr_arbiter_if.slave  bus
);

   localparam int unsigned ID_WIDTH = id_width(NUM_REQ);

   logic                  r_out_valid;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [ID_WIDTH-1:0]   r_out_id;
   logic [ID_WIDTH-1:0]   r_ptr;

   logic                  w_load;
   logic                  w_grant;
   logic                  w_pick_valid;
   logic [ID_WIDTH-1:0]   w_gnt_idx;
   logic [NUM_REQ-1:0]    w_mask;
   logic                  w_last;
   logic [NUM_REQ-1:0]    w_ready;
   logic [ID_WIDTH-1:0]   w_ptr_next;
   logic [DATA_WIDTH-1:0] w_data_sel;

   // rst_ni gating keeps req_ready_o low while reset is asserted.
   assign w_load = rst_ni & ~bus.s_ctrl_stall & ~bus.s_ctrl_flush
                 & (~r_out_valid | bus.m_data_ready);
   assign w_grant = w_load & w_pick_valid;

`ifdef PIPE_ARB_LOCK_EN
   logic                r_lock;
   logic [ID_WIDTH-1:0] r_lock_id;

   always_comb begin
      w_mask = '1;
      if (r_lock) begin
         w_mask            = '0;
         w_mask[r_lock_id] = 1'b1;
      end
   end

   assign w_last = bus.req_last_i[w_gnt_idx];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock    <= 1'b0;
         r_lock_id <= '0;
      end else if (bus.s_ctrl_flush) begin
         r_lock    <= 1'b0;
         r_lock_id <= '0;
      end else if (w_grant) begin
         r_lock    <= ~w_last;
         r_lock_id <= w_gnt_idx;
      end
   end
`else
   assign w_mask = '1;
   assign w_last = 1'b1;
`endif

   rr_pick #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_pick (
      .i_req         (bus.req_valid_i),
      .i_ptr         (r_ptr),
      .i_mask        (w_mask),
      .o_grant_valid (w_pick_valid),
      .o_grant_idx   (w_gnt_idx)
   );

   always_comb begin
      w_ready = '0;
      if (w_grant) begin
         w_ready[w_gnt_idx] = 1'b1;
      end
   end

   assign w_data_sel = bus.req_data_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
   assign w_ptr_next = (w_gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_out_valid <= OUT_VALID_RST;
         r_out_data  <= '0;
         r_out_id    <= '0;
         r_ptr       <= '0;
      end else if (bus.s_ctrl_flush) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_id    <= '0;
         r_ptr       <= '0;
      end else if (w_load) begin
         if (w_pick_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data_sel;
            r_out_id    <= w_gnt_idx;
            // Pointer only moves once a packet completes.
            if (w_last) begin
               r_ptr <= w_ptr_next;
            end
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.req_ready_o   = w_ready;
   assign bus.m_data_valid  = r_out_valid & ~bus.s_ctrl_flush;
   assign bus.m_data_data   = bus.s_ctrl_flush ? '0 : r_out_data;
   assign bus.m_data_id     = bus.s_ctrl_flush ? '0 : r_out_id;
   assign bus.s_status_busy = r_out_valid;

endmodule

// File: tb/tb_pipeline_rr_arbiter.sv
// Directed vector bench for pipeline_rr_arbiter (NUM_REQ=4, DATA_WIDTH=32).
// Adds a packet-lock sequence when PIPE_ARB_LOCK_EN is defined.
module tb_pipeline_rr_arbiter;
   import pipe_arb_pkg::*;

   localparam logic [31:0] D0 = 32'hC0DE_0000;
   localparam logic [31:0] D1 = 32'hC0DE_0001;
   localparam logic [31:0] D2 = 32'hC0DE_0002;
   localparam logic [31:0] D3 = 32'hC0DE_0003;
   localparam logic [31:0] DA = 32'hA5A5_A5A5;

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d2;
      logic        rdy;
      logic        st;
      logic        fl;
      logic [3:0]  e_rr;
      logic        e_mv;
      arb_id_t     e_id;
      logic [31:0] e_data;
      logic        e_busy;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   vec_t vecs [21];

   always #5 clk = ~clk;

   pipeline_rr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

   pipeline_rr_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (32)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   function automatic vec_t mkv(input logic [3:0] v, input logic [31:0] d2, input logic rdy,
                                input logic st, input logic fl, input logic [3:0] e_rr,
                                input logic e_mv, input arb_id_t e_id, input logic [31:0] e_data,
                                input logic e_busy);
      vec_t r;
      r.v = v; r.d2 = d2; r.rdy = rdy; r.st = st; r.fl = fl;
      r.e_rr = e_rr; r.e_mv = e_mv; r.e_id = e_id; r.e_data = e_data; r.e_busy = e_busy;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic apply(input logic [3:0] v, input logic [31:0] d2, input logic rdy,
                        input logic st, input logic fl);
      bus.req_valid_i  = v;
      bus.req_data_i   = {D3, d2, D1, D0};
      bus.m_data_ready = rdy;
      bus.s_ctrl_stall = st;
      bus.s_ctrl_flush = fl;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] rr, input logic mv,
                             input arb_id_t id, input logic [31:0] data, input logic busy);
      check({tag, "_ready"}, 64'(bus.req_ready_o), 64'(rr));
      check({tag, "_mvalid"}, 64'(bus.m_data_valid), 64'(mv));
      check({tag, "_id"}, 64'(bus.m_data_id), 64'(id));
      check({tag, "_data"}, 64'(bus.m_data_data), 64'(data));
      check({tag, "_busy"}, 64'(bus.s_status_busy), 64'(busy));
   endtask

   initial begin
      //                v     d2  rdy st fl  rr    mv id  data busy
      vecs[0]  = mkv(4'hF, D2, 1, 0, 0, 4'h1, 0, 0, 0,  0); // first grant -> req 0
      vecs[1]  = mkv(4'hF, D2, 1, 0, 0, 4'h2, 1, 0, D0, 1);
      vecs[2]  = mkv(4'hF, D2, 1, 0, 0, 4'h4, 1, 1, D1, 1);
      vecs[3]  = mkv(4'hF, D2, 1, 0, 0, 4'h8, 1, 2, D2, 1);
      vecs[4]  = mkv(4'hF, D2, 1, 0, 0, 4'h1, 1, 3, D3, 1);
      vecs[5]  = mkv(4'hF, D2, 1, 0, 0, 4'h2, 1, 0, D0, 1);
      vecs[6]  = mkv(4'h0, D2, 1, 0, 0, 4'h0, 1, 1, D1, 1); // drains, data/id kept
      vecs[7]  = mkv(4'h4, DA, 0, 0, 0, 4'h4, 0, 1, D1, 0); // empty reg loads regardless
      vecs[8]  = mkv(4'h4, DA, 0, 0, 0, 4'h0, 1, 2, DA, 1); // back-pressure x3
      vecs[9]  = mkv(4'h4, DA, 0, 0, 0, 4'h0, 1, 2, DA, 1);
      vecs[10] = mkv(4'h4, DA, 0, 0, 0, 4'h0, 1, 2, DA, 1);
      vecs[11] = mkv(4'h4, DA, 1, 0, 0, 4'h4, 1, 2, DA, 1); // consume + accept
      vecs[12] = mkv(4'h2, D2, 1, 0, 0, 4'h2, 1, 2, DA, 1);
      vecs[13] = mkv(4'hF, D2, 1, 0, 1, 4'h0, 0, 0, 0,  1); // flush over req 1 beat
      vecs[14] = mkv(4'hF, D2, 1, 0, 0, 4'h1, 0, 0, 0,  0); // pointer back at 0
      vecs[15] = mkv(4'hF, D2, 1, 1, 1, 4'h0, 0, 0, 0,  1); // stall+flush
      vecs[16] = mkv(4'hF, D2, 1, 0, 0, 4'h1, 0, 0, 0,  0);
      vecs[17] = mkv(4'hF, D2, 1, 1, 0, 4'h0, 1, 0, D0, 1); // stall alone
      vecs[18] = mkv(4'hF, D2, 1, 1, 0, 4'h0, 1, 0, D0, 1);
      vecs[19] = mkv(4'hF, D2, 1, 0, 0, 4'h2, 1, 0, D0, 1);
      vecs[20] = mkv(4'h0, D2, 0, 0, 0, 4'h0, 1, 1, D1, 1);

`ifdef PIPE_ARB_LOCK_EN
      bus.req_last_i = 4'hF;
`endif
      apply(4'hF, D2, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 4'h0, 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         apply(vecs[i].v, vecs[i].d2, vecs[i].rdy, vecs[i].st, vecs[i].fl);
         #1;
         check_outs($sformatf("row%0d", i), vecs[i].e_rr, vecs[i].e_mv, vecs[i].e_id,
                    vecs[i].e_data, vecs[i].e_busy);
         @(posedge clk);
         #1;
      end

`ifdef PIPE_ARB_LOCK_EN
      // Flush to a known pointer, then req 3 sends a 3-beat packet with req 0 waiting.
      apply(4'h0, D2, 1, 0, 1);
      @(posedge clk);
      #1;
      apply(4'h8, D2, 1, 0, 0);
      bus.req_last_i = 4'h7;
      #1;
      check("lock_a_ready", 64'(bus.req_ready_o), 64'h8);
      @(posedge clk);
      #1;
      apply(4'h9, D2, 1, 0, 0);
      #1;
      check("lock_b_ready", 64'(bus.req_ready_o), 64'h8);
      check("lock_b_id", 64'(bus.m_data_id), 64'd3);
      @(posedge clk);
      #1;
      bus.req_last_i = 4'hF;
      #1;
      check("lock_c_ready", 64'(bus.req_ready_o), 64'h8);
      check("lock_c_id", 64'(bus.m_data_id), 64'd3);
      @(posedge clk);
      #1;
      apply(4'h1, D2, 1, 0, 0);
      #1;
      check("lock_d_ready", 64'(bus.req_ready_o), 64'h1);
      check("lock_d_id", 64'(bus.m_data_id), 64'd3);
      @(posedge clk);
      #1;
      apply(4'h0, D2, 0, 0, 0);
      #1;
      check("lock_e_id", 64'(bus.m_data_id), 64'd0);
      check("lock_e_data", 64'(bus.m_data_data), 64'(D0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
